vga_timing: RTL



---
 rtl/vga_timing.sv | 90 +++++++++
 1 files changed

// File: rtl/vga_timing.sv
// Raster timing generator for the VGA output: pixel/line counters, syncs,
// visible-area flag and line/frame strobes, all advancing on pix_en.
module vga_timing #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       in_frame,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       at_line_last;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       in_frame_nxt;

    assign at_line_last = (x == H_LAST);

    // Next counter values; sync and visible flags are derived from these so
    // the registered outputs line up with the x/y they are presented with.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (pix_en) begin
            if (at_line_last) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
            end else begin
                x_nxt = x + 10'd1;
            end
        end
        hs_nxt       = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? SYNC_ON : SYNC_OFF;
        vs_nxt       = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? SYNC_ON : SYNC_OFF;
        in_frame_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    // Counter and registered output state; reset lands on (0,0) outright.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            hsync    <= SYNC_OFF;
            vsync    <= SYNC_OFF;
            in_frame <= 1'b1;
        end else begin
            x        <= x_nxt;
            y        <= y_nxt;
            hsync    <= hs_nxt;
            vsync    <= vs_nxt;
            in_frame <= in_frame_nxt;
        end
    end

    // Strobes are gated by pix_en so they last one clk even at a slow pixel
    // rate, and are held off while reset is asserted.
    assign line_end  = rst_n & pix_en & at_line_last;
    assign frame_end = line_end & (y == V_LAST);

endmodule
